fetch_stage: RTL and testbench

- Instruction-fetch stage of the 32-bit ARM pipeline, directly upstream of the combinational instruction memory.
- Holds the byte-addressed PC and drives the word-index address into instruction memory.
- Registers the returned instruction and PC+4 into the IF/ID pipeline register.
- Handles hazard freeze, branch redirect and flush (bubble insertion) from later stages.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory link, IF/ID register out.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface fetch_stage_if;
  logic                   freeze;
  logic                   branch_taken;
  logic [`WORD_WIDTH-1:0] branch_addr;
  logic                   flush;
  logic [`WORD_WIDTH-1:0] imem_addr;
  logic [`WORD_WIDTH-1:0] imem_instruction;
  logic [`WORD_WIDTH-1:0] pc_out;
  logic [`WORD_WIDTH-1:0] instruction_out;
  logic                   valid_out;

  modport master (
    input  freeze, branch_taken, branch_addr, flush, imem_instruction,
    output imem_addr, pc_out, instruction_out, valid_out
  );

  modport slave (
    output freeze, branch_taken, branch_addr, flush, imem_instruction,
    input  imem_addr, pc_out, instruction_out, valid_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-indexed imem address and the IF/ID pipeline register.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  stall_cnt
`endif
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr_reg;
  logic [31:0] pc_out_reg;
  logic        valid_reg;
  logic        squash;
  logic        capture;

  // Branch target low bits are discarded to keep the PC word aligned.
  logic [1:0]  unused_branch_low;
  assign unused_branch_low = bus.branch_addr[1:0];

  assign pc_plus4      = pc_reg + 32'd4;
  assign bus.imem_addr = {2'b00, pc_reg[31:2]};
  assign squash        = bus.flush | bus.branch_taken;
  assign capture       = ~squash & ~bus.freeze;

  always_comb begin
    pc_next = pc_reg;
    if (bus.branch_taken)
      pc_next = {bus.branch_addr[31:2], 2'b00};
    else if (!bus.freeze)
      pc_next = pc_plus4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

  // Squash beats freeze so a flush during a stall still inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg  <= NOP_INSTR;
      pc_out_reg <= 32'd0;
      valid_reg  <= 1'b0;
    end else if (squash) begin
      instr_reg  <= NOP_INSTR;
      pc_out_reg <= 32'd0;
      valid_reg  <= 1'b0;
    end else if (capture) begin
      instr_reg  <= bus.imem_instruction;
      pc_out_reg <= pc_plus4;
      valid_reg  <= 1'b1;
    end
  end

  assign bus.instruction_out = instr_reg;
  assign bus.pc_out          = pc_out_reg;
  assign bus.valid_out       = valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_reg <= 32'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      if (capture)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (bus.freeze && !bus.branch_taken)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stub imem returns 0xE000_0000 | word index.
`timescale 1ns/1ps

module tb_fetch_stage;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic [31:0] iaddr;
  } exp_t;

  logic clk;
  logic rst;
  fetch_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.imem_instruction = 32'hE000_0000 | bus.imem_addr;

  int vectors = 0;
  int miscompares = 0;
  exp_t sbq[$];

  // reference state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  int unsigned m_fetch;
  int unsigned m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else
      $display("ok   %s = %h", tag, got);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_pcout = 32'd0;
    m_fetch = 0; m_stall = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, {31'd0, bus.valid_out}, 32'd0);
    check({tag, ".instr"}, bus.instruction_out, 32'd0);
    check({tag, ".pcout"}, bus.pc_out, 32'd0);
    check({tag, ".iaddr"}, bus.imem_addr, 32'd0);
  endtask

  // Called at posedge+1: apply inputs, predict, clock, compare.
  task automatic step(input logic fz, input logic br, input logic fl, input logic [31:0] ba);
    exp_t e;
    bus.freeze = fz; bus.branch_taken = br; bus.flush = fl; bus.branch_addr = ba;
    if (fl || br) begin
      m_valid = 1'b0; m_instr = 32'd0; m_pcout = 32'd0;
    end else if (!fz) begin
      m_valid = 1'b1; m_instr = 32'hE000_0000 | (m_pc >> 2); m_pcout = m_pc + 32'd4;
      m_fetch++;
    end
    if (fz && !br) m_stall++;
    if (br) m_pc = {ba[31:2], 2'b00};
    else if (!fz) m_pc = m_pc + 32'd4;
    sbq.push_back('{m_valid, m_instr, m_pcout, m_pc >> 2});
    @(posedge clk); #1;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.flush = 1'b0; bus.branch_addr = 32'd0;
    if (sbq.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL sb.empty got=0 exp=1");
    end else begin
      e = sbq.pop_front();
      check("valid", {31'd0, bus.valid_out}, {31'd0, e.valid});
      check("instr", bus.instruction_out, e.instr);
      check("pcout", bus.pc_out, e.pcout);
      check("iaddr", bus.imem_addr, e.iaddr);
    end
  endtask

  // Asynchronous reset pulse landing mid-cycle; entered at posedge+1.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.flush = 1'b0; bus.branch_addr = 32'd0;
    model_reset();
    #1 check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // free-running fetch
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    check("free.pcout16", bus.pc_out, 32'd16);
    check("free.instr3", bus.instruction_out, 32'hE000_0003);

    // freeze at pc = 8
    async_reset("rst1");
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
    check("frz.pcout", bus.pc_out, 32'd8);
    check("frz.iaddr", bus.imem_addr, 32'd2);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("frz.resume", bus.instruction_out, 32'hE000_0002);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    // branch to 148, then redirect to 112
    step(1'b0, 1'b1, 1'b0, 32'd148);
    check("br.iaddr148", bus.imem_addr, 32'd37);
    step(1'b0, 1'b1, 1'b0, 32'd112);
    check("br.bubble", {31'd0, bus.valid_out}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("br.target", bus.instruction_out, 32'hE000_001C);
    check("br.pcout", bus.pc_out, 32'd116);

    // branch + freeze with misaligned target
    step(1'b1, 1'b1, 1'b0, 32'h0000_003F);
    check("brfz.iaddr", bus.imem_addr, 32'h0000_000F);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("brfz.instr", bus.instruction_out, 32'hE000_000F);

    // flush + freeze, then mid-cycle async reset
    step(1'b1, 1'b0, 1'b1, 32'd0);
    check("flfz.iaddr", bus.imem_addr, 32'h0000_0010);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    async_reset("rst2");
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("rst2.first", bus.instruction_out, 32'hE000_0000);

    // PC wrap at top of address space
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("wrap.pcout", bus.pc_out, 32'd0);

`ifdef IF_PERF_CNT_EN
    async_reset("rst3");
    check("perf.fetch0", fetch_cnt, 32'd0);
    check("perf.stall0", stall_cnt, 32'd0);
    for (int i = 0; i < 10; i++)
      step((i >= 2 && i <= 4) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0, 32'd40);
    check("perf.fetch", fetch_cnt, 32'd6);
    check("perf.stall", stall_cnt, 32'd3);
    check("perf.fetch.model", fetch_cnt, 32'(m_fetch));
    check("perf.stall.model", stall_cnt, 32'(m_stall));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
